// File: rtl/obf_key_pkg.sv
// obf_key_pkg
// Shared definitions for the obfuscation key loader slice.
//   key_state_t     : loader FSM states (IDLE, SHIFT, CHECK, LOCKED)
//   KEY_TRANSPARENT : key value that leaves the obfuscated core unmodified
//   frame_len()     : number of serial beats in one frame for a given key width
package obf_key_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } key_state_t;

    // 00 = transparent, 01 = invert protected net, 10 = force 1, 11 = force 0
    localparam logic [1:0] KEY_TRANSPARENT = 2'b00;

    // A frame carries every key bit followed by one even-parity bit.
    function automatic int frame_len(input int key_w);
        return key_w + 1;
    endfunction

endpackage

// File: rtl/obf_key_shreg.sv
// obf_key_shreg
// Shadow storage for a key frame in flight: key bits, the parity beat and the
// beat counter. The loader FSM decides when to load, shift or clear.
//   clk, reset : clock and synchronous active-high reset
//   clear      : drop the current frame contents
//   load       : first beat of a frame, written to shadow[0], count becomes 1
//   shift      : later beat, written to shadow[count] or to parity
//   bit_in     : serial beat value
//   shadow     : collected key bits (bit 0 = first beat)
//   parity     : captured parity beat
//   count      : number of beats captured so far
module obf_key_shreg
    import obf_key_pkg::*;
#(
    parameter int KEY_W = 2,
    parameter int CNT_W = $clog2(KEY_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  logic             bit_in,
    output logic [KEY_W-1:0] shadow,
    output logic             parity,
    output logic [CNT_W-1:0] count
);

    // The counter doubles as the write pointer: beats below KEY_W land in the
    // shadow key, the beat at index KEY_W is the parity bit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shadow <= '0;
            parity <= 1'b0;
            count  <= '0;
        end else if (load) begin
            shadow    <= '0;
            shadow[0] <= bit_in;
            parity    <= 1'b0;
            count     <= CNT_W'(1);
        end else if (shift) begin
            for (int i = 0; i < KEY_W; i++) begin
                if (count == CNT_W'(i)) begin
                    shadow[i] <= bit_in;
                end
            end
            if (count == CNT_W'(KEY_W)) begin
                parity <= bit_in;
            end
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/obf_key_loader.sv
// obf_key_loader
// Receives a serial key frame (KEY_W bits LSB first plus one even-parity bit),
// checks parity and framing, and only then publishes the key on D. D never
// shows a partial key: it changes solely on a passing check or on reset.
//   clk, reset : clock and synchronous active-high reset
//   key_valid  : a beat is offered on key_bit
//   key_bit    : serial frame data
//   key_last   : marks the parity beat of a frame
//   relock     : leave LOCKED and accept a new frame
//   key_ready  : loader accepts a beat this cycle
//   D          : key bus to the obfuscated core
//   key_loaded : D holds a parity-checked key
//   key_err    : one-cycle pulse when a frame is rejected
module obf_key_loader
    import obf_key_pkg::*;
#(
    parameter int KEY_W = 2,
    parameter int CNT_W = $clog2(KEY_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    input  logic             key_bit,
    input  logic             key_last,
    input  logic             relock,
    output logic             key_ready,
    output logic [KEY_W-1:0] D,
    output logic             key_loaded,
    output logic             key_err
);

    localparam int PARITY_IDX = frame_len(KEY_W) - 1;

    key_state_t       state;
    logic             frame_err;
    logic             xfer;
    logic             is_parity_beat;
    logic             parity_ok;
    logic             sr_load;
    logic             sr_shift;
    logic             sr_clear;
    logic [KEY_W-1:0] shadow;
    logic             parity;
    logic [CNT_W-1:0] count;

    assign xfer           = key_valid && key_ready;
    assign is_parity_beat = (count == CNT_W'(PARITY_IDX));
    // Even parity: all key bits plus the parity beat XOR to zero.
    assign parity_ok      = ~((^shadow) ^ parity);

    assign sr_load  = (state == IDLE)  && xfer;
    assign sr_shift = (state == SHIFT) && xfer;
    assign sr_clear = (state == CHECK);

    obf_key_shreg #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W)
    ) u_shreg (
        .clk    (clk),
        .reset  (reset),
        .clear  (sr_clear),
        .load   (sr_load),
        .shift  (sr_shift),
        .bit_in (key_bit),
        .shadow (shadow),
        .parity (parity),
        .count  (count)
    );

    // Loader FSM with registered outputs. A misplaced key_last only sets
    // frame_err; the frame still runs to its full length so the receiver
    // stays aligned with the sender's beat count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            frame_err  <= 1'b0;
            key_ready  <= 1'b1;
            D          <= KEY_W'(KEY_TRANSPARENT);
            key_loaded <= 1'b0;
            key_err    <= 1'b0;
        end else begin
            key_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        frame_err <= key_last;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        if (key_last != is_parity_beat) begin
                            frame_err <= 1'b1;
                        end
                        if (is_parity_beat) begin
                            state     <= CHECK;
                            key_ready <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    frame_err <= 1'b0;
                    if (parity_ok && !frame_err) begin
                        D          <= shadow;
                        key_loaded <= 1'b1;
                        state      <= LOCKED;
                    end else begin
                        key_err   <= 1'b1;
                        key_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                LOCKED: begin
                    if (relock) begin
                        key_loaded <= 1'b0;
                        key_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    key_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obf_key_loader.sv
// tb_obf_key_loader
// Self-checking bench for obf_key_loader: a table of whole frames with
// hand-computed results, hand-written corner sequences (LOCKED behaviour,
// reset mid-frame, reset during CHECK) and 1000 random frames with random
// valid gaps, all compared every cycle against a frame-level reference model.
module tb_obf_key_loader;

    localparam int KEY_W = 2;

    logic             clk;
    logic             reset;
    logic             key_valid;
    logic             key_bit;
    logic             key_last;
    logic             relock;
    logic             key_ready;
    logic [KEY_W-1:0] D;
    logic             key_loaded;
    logic             key_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: beats collected per frame, judged when complete.
    bit               beats[$];
    bit               lasts[$];
    bit               m_checking;
    bit               m_locked;
    logic [KEY_W-1:0] m_d;
    bit               m_loaded;
    bit               m_err;

    typedef struct {
        string            name;
        bit [KEY_W:0]     bits;
        bit [KEY_W:0]     lasts;
        logic [KEY_W-1:0] exp_d;
        bit               exp_err;
    } vec_t;

    vec_t vecs[8];

    obf_key_loader #(.KEY_W(KEY_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .key_last   (key_last),
        .relock     (relock),
        .key_ready  (key_ready),
        .D          (D),
        .key_loaded (key_loaded),
        .key_err    (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level rules: a frame is judged on the cycle after its last beat.
    task automatic modelStep(input bit v, input bit b, input bit l, input bit rl, input bit rst);
        if (rst) begin
            beats.delete();
            lasts.delete();
            m_checking = 0;
            m_locked   = 0;
            m_d        = '0;
            m_loaded   = 0;
            m_err      = 0;
        end else begin
            m_err = 0;
            if (m_checking) begin
                bit par;
                bit framing_ok;
                par        = 0;
                framing_ok = 1;
                foreach (beats[i]) begin
                    par = par ^ beats[i];
                    if (lasts[i] != (i == KEY_W)) framing_ok = 0;
                end
                if (!par && framing_ok) begin
                    for (int i = 0; i < KEY_W; i++) m_d[i] = beats[i];
                    m_loaded = 1;
                    m_locked = 1;
                end else begin
                    m_err = 1;
                end
                beats.delete();
                lasts.delete();
                m_checking = 0;
            end else if (m_locked) begin
                if (rl) begin
                    m_locked = 0;
                    m_loaded = 0;
                end
            end else if (v) begin
                beats.push_back(b);
                lasts.push_back(l);
                if (beats.size() == KEY_W + 1) m_checking = 1;
            end
        end
    endtask

    task automatic checkOutput();
        check("D", 32'(D), 32'(m_d));
        check("key_loaded", 32'(key_loaded), 32'(m_loaded));
        check("key_err", 32'(key_err), 32'(m_err));
        check("key_ready", 32'(key_ready), 32'(!(m_checking || m_locked)));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample #1 later.
    task automatic applyStimulus(input bit v, input bit b, input bit l, input bit rl, input bit rst);
        key_valid = v;
        key_bit   = b;
        key_last  = l;
        relock    = rl;
        reset     = rst;
        @(posedge clk);
        modelStep(v, b, l, rl, rst);
        #1;
        checkOutput();
    endtask

    task automatic sendFrame(input bit [KEY_W:0] fb, input bit [KEY_W:0] fl);
        for (int i = 0; i <= KEY_W; i++) applyStimulus(1, fb[i], fl[i], 0, 0);
    endtask

    initial begin
        // bits/lasts are indexed by beat number (bit 0 = first beat)
        vecs[0] = '{"odd_parity",    3'b111, 3'b100, 2'b00, 1'b1};
        vecs[1] = '{"early_last",    3'b010, 3'b010, 2'b00, 1'b1};
        vecs[2] = '{"load_01",       3'b101, 3'b100, 2'b01, 1'b0};
        vecs[3] = '{"load_10",       3'b110, 3'b100, 2'b10, 1'b0};
        vecs[4] = '{"load_11",       3'b011, 3'b100, 2'b11, 1'b0};
        vecs[5] = '{"load_00",       3'b000, 3'b100, 2'b00, 1'b0};
        vecs[6] = '{"last_on_first", 3'b101, 3'b101, 2'b00, 1'b1};
        vecs[7] = '{"no_last",       3'b110, 3'b000, 2'b00, 1'b1};

        key_valid = 0; key_bit = 0; key_last = 0; relock = 0; reset = 1;

        // Reset state
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(1, 1, 1, 1, 1);
        check("rst_D", 32'(D), 32'h0);
        check("rst_key_loaded", 32'(key_loaded), 32'h0);
        check("rst_key_err", 32'(key_err), 32'h0);
        check("rst_key_ready", 32'(key_ready), 32'h1);
        applyStimulus(0, 0, 0, 0, 0);

        // Table-driven frames with hand-computed results
        for (int k = 0; k < 8; k++) begin
            logic [KEY_W-1:0] prev_d;
            prev_d = D;
            sendFrame(vecs[k].bits, vecs[k].lasts);
            check({vecs[k].name, "_check_ready"}, 32'(key_ready), 32'h0);
            check({vecs[k].name, "_check_D_held"}, 32'(D), 32'(prev_d));
            applyStimulus(0, 0, 0, 0, 0);
            check({vecs[k].name, "_D"}, 32'(D), 32'(vecs[k].exp_d));
            check({vecs[k].name, "_err"}, 32'(key_err), 32'(vecs[k].exp_err));
            check({vecs[k].name, "_loaded"}, 32'(key_loaded), 32'(!vecs[k].exp_err));
            applyStimulus(0, 0, 0, 1, 0);
            check({vecs[k].name, "_ready_after"}, 32'(key_ready), 32'h1);
            check({vecs[k].name, "_err_cleared"}, 32'(key_err), 32'h0);
        end

        // LOCKED ignores beats; relock keeps D until the next good frame
        sendFrame(3'b110, 3'b100);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) applyStimulus(1, 1, 1, 0, 0);
        check("locked_ready", 32'(key_ready), 32'h0);
        check("locked_D", 32'(D), 32'h2);
        applyStimulus(0, 0, 0, 1, 0);
        check("relock_D_kept", 32'(D), 32'h2);
        check("relock_loaded", 32'(key_loaded), 32'h0);
        sendFrame(3'b011, 3'b100);
        applyStimulus(0, 0, 0, 0, 0);
        check("reload_D", 32'(D), 32'h3);

        // Reset after one beat discards the frame
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        check("midrst_D", 32'(D), 32'h0);
        check("midrst_err", 32'(key_err), 32'h0);
        check("midrst_count", 32'(dut.u_shreg.count), 32'h0);
        sendFrame(3'b000, 3'b100);
        applyStimulus(0, 0, 0, 0, 0);
        check("after_rst_D", 32'(D), 32'h0);
        check("after_rst_loaded", 32'(key_loaded), 32'h1);

        // Reset during CHECK of a bad frame gives no key_err
        applyStimulus(0, 0, 0, 1, 0);
        sendFrame(3'b111, 3'b100);
        applyStimulus(0, 0, 0, 0, 1);
        check("chk_rst_err", 32'(key_err), 32'h0);
        applyStimulus(0, 0, 0, 0, 0);
        check("chk_rst_err_next", 32'(key_err), 32'h0);

        // Random frames with gaps, stray relock pulses and occasional faults
        for (int f = 0; f < 1000; f++) begin
            bit [KEY_W:0] fb;
            bit [KEY_W:0] fl;
            int kind;
            kind = int'($urandom_range(0, 9));
            fb = '0;
            fb[KEY_W-1:0] = KEY_W'($urandom);
            fb[KEY_W] = ^fb[KEY_W-1:0];
            if (kind == 0) fb[KEY_W] = ~fb[KEY_W];
            fl = '0;
            fl[KEY_W] = 1'b1;
            if (kind == 1) fl[$urandom_range(0, KEY_W)] ^= 1'b1;
            for (int i = 0; i <= KEY_W; i++) begin
                int gap;
                gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                repeat (gap) applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                           $urandom_range(0, 7) == 0, 0);
                applyStimulus(1, fb[i], fl[i], 0, 0);
            end
            applyStimulus(0, 0, 0, 0, 0);
            if (m_locked) begin
                repeat ($urandom_range(0, 2)) applyStimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
                applyStimulus(0, 0, 0, 1, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
